// File: rtl/boot_dumper_pkg.sv
// Shared peripheral definitions for the boot dumper: FSM states, AXI encodings,
// default frame bytes and small byte helpers.
package boot_dumper_pkg;

    localparam int AXI_DW = 32;
    localparam int AXI_AW = 32;
    localparam int AXI_SW = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam logic [7:0] ON_BYTE_DEF  = 8'hAA;
    localparam logic [7:0] STP_BYTE_DEF = 8'h55;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR, ST_AR, ST_RD, ST_TXW, ST_CSUM, ST_STP, ST_DONE
    } state_e;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] byte_sum(input logic [31:0] w);
        return w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endfunction

endpackage

// File: rtl/boot_dumper_if.sv
// AXI4 bus (32-bit data/address) between the boot dumper and the fabric.
interface boot_dumper_if;
    import boot_dumper_pkg::*;

    logic [AXI_AW-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [AXI_DW-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic              rlast;
    logic [AXI_AW-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [AXI_DW-1:0] wdata;
    logic [AXI_SW-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
               awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, rlast, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
               awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, rlast, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/boot_dumper_uart_tx_byte.sv
// UART 8N1 byte transmitter; ready pulses in the last cycle of the stop bit so
// a byte offered in that cycle follows with no idle gap.
module uart_tx_byte #(
    parameter int unsigned CLK_DIV = 54
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       TX
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic        active_r;
    logic [15:0] div_r;
    logic [3:0]  bit_r;
    logic [8:0]  shift_r;
    logic        tx_r;
    logic        bit_end_s;
    logic        accept_s;

    assign bit_end_s = active_r && (div_r == DIV_LAST);
    assign ready     = bit_end_s && (bit_r == 4'd9);
    assign accept_s  = valid && (!active_r || ready);
    assign TX        = tx_r;

    // Bit timing and shift register; bit_r 0 is the start bit, 9 the stop bit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            active_r <= 1'b0;
            div_r    <= 16'd0;
            bit_r    <= 4'd0;
            shift_r  <= 9'h1FF;
            tx_r     <= 1'b1;
        end else if (accept_s) begin
            active_r <= 1'b1;
            div_r    <= 16'd0;
            bit_r    <= 4'd0;
            shift_r  <= {1'b1, data};
            tx_r     <= 1'b0;
        end else if (bit_end_s) begin
            div_r <= 16'd0;
            if (bit_r == 4'd9) begin
                active_r <= 1'b0;
                tx_r     <= 1'b1;
            end else begin
                tx_r    <= shift_r[0];
                shift_r <= {1'b1, shift_r[8:1]};
                bit_r   <= bit_r + 4'd1;
            end
        end else if (active_r) begin
            div_r <= div_r + 16'd1;
        end
    end

endmodule

// File: rtl/boot_dumper.sv
// Reads WordCnt words over AXI4 and streams them on the UART as
// header, little-endian data bytes, modulo-256 checksum, trailer.
module boot_dumper
    import boot_dumper_pkg::*;
#(
    parameter int unsigned CLK_DIV = 54,
    parameter logic [7:0]  ONbyte  = ON_BYTE_DEF,
    parameter logic [7:0]  STPbyte = STP_BYTE_DEF,
    parameter logic [3:0]  AXI_ID  = 4'h0
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Start,
    input  logic [31:0]   BaseAddr,
    input  logic [15:0]   WordCnt,
    boot_dumper_if.master axiBus,
    output logic          TX,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);

    state_e      state_r, state_nxt;
    logic        launched_r, launched_nxt;
    logic [1:0]  byte_idx_r, byte_idx_nxt;
    logic [31:0] addr_r;
    logic [15:0] cnt_r;
    logic [31:0] word_r;
    logic [7:0]  csum_r;
    logic        busy_r, done_r, err_r, arvalid_r, rready_r;
    logic        tx_valid_s, tx_ready_s;
    logic [7:0]  tx_data_s;
    logic        start_acc_s, rd_fire_s, word_adv_s;
    logic        unused_s;

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .Clk   (Clk),
        .Rst   (Rst),
        .data  (tx_data_s),
        .valid (tx_valid_s),
        .ready (tx_ready_s),
        .TX    (TX)
    );

    assign axiBus.araddr  = addr_r;
    assign axiBus.arvalid = arvalid_r;
    assign axiBus.arid    = AXI_ID;
    assign axiBus.arlen   = 8'd0;
    assign axiBus.arsize  = SIZE_4B;
    assign axiBus.arburst = BURST_INCR;
    assign axiBus.rready  = rready_r;
    assign axiBus.awaddr  = 32'd0;
    assign axiBus.awvalid = 1'b0;
    assign axiBus.wdata   = 32'd0;
    assign axiBus.wstrb   = 4'd0;
    assign axiBus.wvalid  = 1'b0;
    assign axiBus.bready  = 1'b1;
    assign unused_s = ^{axiBus.rlast, axiBus.awready, axiBus.wready, axiBus.bvalid, axiBus.bresp};

    assign Busy = busy_r;
    assign Done = done_r;
    assign Err  = err_r;

    // Next state; launched_r marks that the current state's byte is on the wire,
    // and the following byte is offered in the ready cycle to stay gapless.
    always_comb begin
        state_nxt    = state_r;
        launched_nxt = launched_r;
        byte_idx_nxt = byte_idx_r;
        tx_valid_s   = 1'b0;
        tx_data_s    = 8'h00;
        start_acc_s  = 1'b0;
        rd_fire_s    = 1'b0;
        word_adv_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    start_acc_s  = 1'b1;
                    launched_nxt = 1'b0;
                    state_nxt    = ST_HDR;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!launched_r) begin
                    tx_valid_s   = 1'b1;
                    tx_data_s    = ONbyte;
                    launched_nxt = 1'b1;
                end else if (tx_ready_s) begin
                    if (cnt_r != 16'd0) begin
                        launched_nxt = 1'b0;
                        state_nxt    = ST_AR;
                    end else begin
                        tx_valid_s = 1'b1;
                        tx_data_s  = csum_r;
                        state_nxt  = ST_CSUM;
                    end
                end else begin
                    state_nxt = ST_HDR;
                end
            end
            ST_AR: begin
                if (axiBus.arready) begin
                    state_nxt = ST_RD;
                end else begin
                    state_nxt = ST_AR;
                end
            end
            ST_RD: begin
                if (axiBus.rvalid) begin
                    rd_fire_s    = 1'b1;
                    launched_nxt = 1'b0;
                    byte_idx_nxt = 2'd0;
                    state_nxt    = ST_TXW;
                end else begin
                    state_nxt = ST_RD;
                end
            end
            ST_TXW: begin
                if (!launched_r) begin
                    tx_valid_s   = 1'b1;
                    tx_data_s    = byte_sel(word_r, byte_idx_r);
                    launched_nxt = 1'b1;
                end else if (tx_ready_s) begin
                    if (byte_idx_r != 2'd3) begin
                        byte_idx_nxt = byte_idx_r + 2'd1;
                        tx_valid_s   = 1'b1;
                        tx_data_s    = byte_sel(word_r, byte_idx_r + 2'd1);
                    end else begin
                        word_adv_s   = 1'b1;
                        byte_idx_nxt = 2'd0;
                        if (cnt_r != 16'd1) begin
                            launched_nxt = 1'b0;
                            state_nxt    = ST_AR;
                        end else begin
                            tx_valid_s = 1'b1;
                            tx_data_s  = csum_r;
                            state_nxt  = ST_CSUM;
                        end
                    end
                end else begin
                    state_nxt = ST_TXW;
                end
            end
            ST_CSUM: begin
                if (!launched_r) begin
                    tx_valid_s   = 1'b1;
                    tx_data_s    = csum_r;
                    launched_nxt = 1'b1;
                end else if (tx_ready_s) begin
                    tx_valid_s = 1'b1;
                    tx_data_s  = STPbyte;
                    state_nxt  = ST_STP;
                end else begin
                    state_nxt = ST_CSUM;
                end
            end
            ST_STP: begin
                if (tx_ready_s) begin
                    launched_nxt = 1'b0;
                    state_nxt    = ST_DONE;
                end else begin
                    state_nxt = ST_STP;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                launched_nxt = 1'b0;
                state_nxt    = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and the address/count/checksum datapath.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            launched_r <= 1'b0;
            byte_idx_r <= 2'd0;
            addr_r     <= 32'd0;
            cnt_r      <= 16'd0;
            word_r     <= 32'd0;
            csum_r     <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            launched_r <= launched_nxt;
            byte_idx_r <= byte_idx_nxt;
            busy_r     <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            done_r     <= (state_nxt == ST_DONE);
            arvalid_r  <= (state_nxt == ST_AR);
            rready_r   <= (state_nxt == ST_RD);
            if (start_acc_s) begin
                addr_r <= {BaseAddr[31:2], 2'b00};
                cnt_r  <= WordCnt;
                csum_r <= 8'd0;
                err_r  <= 1'b0;
            end else if (rd_fire_s) begin
                word_r <= axiBus.rdata;
                csum_r <= csum_r + byte_sum(axiBus.rdata);
                if (axiBus.rresp != RESP_OKAY) begin
                    err_r <= 1'b1;
                end
            end else if (word_adv_s) begin
                addr_r <= addr_r + 32'd4;
                cnt_r  <= cnt_r - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_boot_dumper.sv
// Directed bench for boot_dumper: AXI read slave model, UART byte monitor and
// hand-computed frames.
module tb_boot_dumper;
    import boot_dumper_pkg::*;

    localparam int CLK_DIV = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [31:0] BaseAddr = 32'd0;
    logic [15:0] WordCnt = 16'd0;
    logic        TX, Busy, Done, Err;

    boot_dumper_if bus();

    boot_dumper #(.CLK_DIV(CLK_DIV)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .BaseAddr (BaseAddr),
        .WordCnt  (WordCnt),
        .axiBus   (bus),
        .TX       (TX),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // AXI read slave: arready after stall_cfg waiting cycles, data one cycle later
    int          stall_cfg = 0;
    logic [1:0]  resp_cfg  = 2'b00;
    logic        force_ff  = 1'b0;
    logic        r_pend;
    logic [31:0] r_data;
    int          ar_wait;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h4433_2211;
            32'h0000_0104: return 32'h8877_6655;
            default:       return a;
        endcase
    endfunction

    assign bus.arready = (ar_wait >= stall_cfg);
    assign bus.rvalid  = r_pend;
    assign bus.rdata   = r_data;
    assign bus.rresp   = resp_cfg;
    assign bus.rlast   = 1'b1;
    assign bus.awready = 1'b0;
    assign bus.wready  = 1'b0;
    assign bus.bvalid  = 1'b0;
    assign bus.bresp   = 2'b00;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pend  <= 1'b0;
            r_data  <= 32'd0;
            ar_wait <= 0;
        end else if (bus.arvalid && bus.arready) begin
            r_pend  <= 1'b1;
            r_data  <= force_ff ? 32'hFFFF_FFFF : mem_rd(bus.araddr);
            ar_wait <= 0;
        end else begin
            if (bus.arvalid) ar_wait <= ar_wait + 1;
            if (bus.rvalid && bus.rready) r_pend <= 1'b0;
        end
    end

    // Free-running observers; tests work on differences of these
    int          busy_cyc = 0, done_cnt = 0, arv_cyc = 0, ar_chg = 0, tx_low_ar = 0;
    logic [31:0] ar_log[$];
    logic        prev_arv = 1'b0;
    logic [31:0] prev_ara = 32'd0;

    always @(negedge Clk) begin
        if (Busy) busy_cyc <= busy_cyc + 1;
        if (Done) done_cnt <= done_cnt + 1;
        if (bus.arvalid) arv_cyc <= arv_cyc + 1;
        if (bus.arvalid && bus.arready) ar_log.push_back(bus.araddr);
        if (bus.arvalid && prev_arv && (bus.araddr != prev_ara)) ar_chg <= ar_chg + 1;
        if (bus.arvalid && !TX) tx_low_ar <= tx_low_ar + 1;
        prev_arv <= bus.arvalid;
        prev_ara <= bus.araddr;
    end

    // UART monitor: sample mid-bit, CLK_DIV cycles apart
    logic [7:0] rx_q[$];
    logic [7:0] mon_b;
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst && TX === 1'b0) begin
                repeat (CLK_DIV / 2) @(negedge Clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge Clk);
                    mon_b[i] = TX;
                end
                repeat (CLK_DIV) @(negedge Clk);
                rx_q.push_back(mon_b);
            end
        end
    end

    int         f_rx0, f_busy0, f_done0, f_arv0, f_ara0, f_chg0, f_txl0;
    logic       f_err_early;
    logic [7:0] exp_q[$];

    task automatic run_frame(input logic [31:0] base, input logic [15:0] cnt, input int restart_at);
        logic got;
        got     = 1'b0;
        f_rx0   = rx_q.size();
        f_busy0 = busy_cyc;
        f_done0 = done_cnt;
        f_arv0  = arv_cyc;
        f_ara0  = ar_log.size();
        f_chg0  = ar_chg;
        f_txl0  = tx_low_ar;
        @(negedge Clk);
        BaseAddr = base;
        WordCnt  = cnt;
        Start    = 1'b1;
        @(negedge Clk);
        Start    = 1'b0;
        BaseAddr = 32'h0000_0200;
        WordCnt  = 16'd5;
        f_err_early = Err;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge Clk);
            Start = (restart_at != 0 && i == restart_at);
            if (Done) got = 1'b1;
        end
        Start = 1'b0;
        check_val("done_seen", {31'd0, got}, 32'd1);
        repeat (4) @(negedge Clk);
    endtask

    task automatic check_frame(input string tag);
        check_val({tag, "_len"}, rx_q.size() - f_rx0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (f_rx0 + i < rx_q.size())
                check_val($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[f_rx0 + i]}, {24'd0, exp_q[i]});
        end
        check_val({tag, "_done"}, done_cnt - f_done0, 32'd1);
        check_val({tag, "_busy_end"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic check_ar(input string tag, input logic [31:0] a0, input logic [31:0] a1);
        check_val({tag, "_nar"}, ar_log.size() - f_ara0, 32'd2);
        if (ar_log.size() >= f_ara0 + 2) begin
            check_val({tag, "_ar0"}, ar_log[f_ara0], a0);
            check_val({tag, "_ar1"}, ar_log[f_ara0 + 1], a1);
        end
    endtask

    initial begin
        logic reached;
        repeat (3) @(negedge Clk);
        check_val("rst_tx", {31'd0, TX}, 32'd1);
        check_val("rst_busy", {31'd0, Busy}, 32'd0);
        check_val("rst_done", {31'd0, Done}, 32'd0);
        check_val("rst_err", {31'd0, Err}, 32'd0);
        check_val("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
        check_val("rst_rready", {31'd0, bus.rready}, 32'd0);
        check_val("rst_araddr", bus.araddr, 32'd0);
        check_val("tie_awvalid", {31'd0, bus.awvalid}, 32'd0);
        check_val("tie_bready", {31'd0, bus.bready}, 32'd1);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);

        // Two words; checksum 0x11*(1+..+8) = 0x264 -> 0x64.
        // Busy: 1 launch cycle + 11 bytes*40 + 3 cycles (AR, RD, launch) per word.
        run_frame(32'h0000_0100, 16'd2, 0);
        exp_q = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64, 8'h55};
        check_frame("t1");
        check_val("t1_err", {31'd0, Err}, 32'd0);
        check_val("t1_busy_cyc", busy_cyc - f_busy0, 32'd447);
        check_val("t1_arsize", {29'd0, bus.arsize}, 32'd2);
        check_val("t1_arburst", {30'd0, bus.arburst}, 32'd1);
        check_ar("t1", 32'h0000_0100, 32'h0000_0104);

        // Empty frame: header, zero checksum, trailer; 1 + 3*40 busy cycles
        run_frame(32'h0000_0300, 16'd0, 0);
        exp_q = '{8'hAA, 8'h00, 8'h55};
        check_frame("t2");
        check_val("t2_arvalid_cyc", arv_cyc - f_arv0, 32'd0);
        check_val("t2_busy_cyc", busy_cyc - f_busy0, 32'd121);

        // arready stalled 20 cycles, SLVERR with all-ones data; 4*0xFF = 0x3FC -> 0xFC
        stall_cfg = 20;
        resp_cfg  = 2'b10;
        force_ff  = 1'b1;
        run_frame(32'h0000_0100, 16'd1, 0);
        exp_q = '{8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h55};
        check_frame("t3");
        check_val("t3_err", {31'd0, Err}, 32'd1);
        check_val("t3_araddr_chg", ar_chg - f_chg0, 32'd0);
        check_val("t3_arvalid_cyc", arv_cyc - f_arv0, 32'd21);
        check_val("t3_tx_low_in_ar", tx_low_ar - f_txl0, 32'd0);
        stall_cfg = 0;
        resp_cfg  = 2'b00;
        force_ff  = 1'b0;

        // The next accepted Start clears Err
        run_frame(32'h0000_0100, 16'd0, 0);
        check_val("t3b_err_after_start", {31'd0, f_err_early}, 32'd0);
        check_val("t3b_err_end", {31'd0, Err}, 32'd0);

        // Address wrap; default memory returns the address itself -> FC+FF*3 = 0x3F9 -> 0xF9
        run_frame(32'hFFFF_FFFC, 16'd2, 0);
        exp_q = '{8'hAA, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF9, 8'h55};
        check_frame("t4");
        check_ar("t4", 32'hFFFF_FFFC, 32'h0000_0000);

        // Unaligned base is forced to a word boundary; a second Start mid-frame is ignored
        run_frame(32'h0000_0103, 16'd2, 100);
        exp_q = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64, 8'h55};
        check_frame("t5");
        check_ar("t5", 32'h0000_0100, 32'h0000_0104);
        repeat (20) @(negedge Clk);
        check_val("t5_no_extra_done", done_cnt - f_done0, 32'd1);
        check_val("t5_idle_busy", {31'd0, Busy}, 32'd0);

        // Reset in the middle of the second data byte
        f_rx0 = rx_q.size();
        @(negedge Clk);
        BaseAddr = 32'h0000_0100;
        WordCnt  = 16'd2;
        Start    = 1'b1;
        @(negedge Clk);
        Start   = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge Clk);
            if (rx_q.size() >= f_rx0 + 2) reached = 1'b1;
        end
        check_val("t6_two_bytes_seen", {31'd0, reached}, 32'd1);
        repeat (8) @(negedge Clk);
        check_val("t6_tx_low_before_rst", {31'd0, TX}, 32'd0);
        Rst = 1'b1;
        #1;
        check_val("t6_rst_tx", {31'd0, TX}, 32'd1);
        check_val("t6_rst_busy", {31'd0, Busy}, 32'd0);
        check_val("t6_rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        repeat (60) @(negedge Clk);
        run_frame(32'h0000_0100, 16'd2, 0);
        check_frame("t6");
        check_val("t6_err", {31'd0, Err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
